// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with packet-level grant hold and forced release
// after MAX_HOLD transfers. A fixed one-hot mode bypasses the rotating pointer.
module rr_hold_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_enable,
  input  logic [NUM_REQ-1:0] single_mask,
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] base_ptr
);

  // state | meaning
  // IDLE  | no grant; arbitrate this cycle
  // HOLD  | grant locked to one requester until release
  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_REQ-1:0]   REQ_ONE   = NUM_REQ'(1);
  localparam logic [2*NUM_REQ-1:0] DBL_ONE   = (2*NUM_REQ)'(1);

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_grant_valid;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [NUM_REQ-1:0]   r_base_ptr;
  logic [CNT_W-1:0]     r_hold_cnt;
  logic                 r_rr_mode;

  state_t               w_next_state;
  logic [NUM_REQ-1:0]   w_next_grant;
  logic [IDX_W-1:0]     w_next_idx;
  logic [NUM_REQ-1:0]   w_next_base;
  logic [CNT_W-1:0]     w_next_cnt;
  logic                 w_next_rr_mode;

  logic [2*NUM_REQ-1:0] w_rr_dbl;
  logic [2*NUM_REQ-1:0] w_rr_low;
  logic [NUM_REQ-1:0]   w_rr_gnt;
  logic [NUM_REQ-1:0]   w_fix_req;
  logic [NUM_REQ-1:0]   w_fix_gnt;
  logic                 w_owner_req;
  logic                 w_xfer;
  logic                 w_last;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_max_hit;
  logic                 w_release;

  // Upper copy handles the wrap: bits below base_ptr are only reachable there.
  assign w_rr_dbl  = {request, request & ~(r_base_ptr - REQ_ONE)};
  assign w_rr_low  = w_rr_dbl & (~w_rr_dbl + DBL_ONE);
  assign w_rr_gnt  = w_rr_low[NUM_REQ-1:0] | w_rr_low[2*NUM_REQ-1:NUM_REQ];

  assign w_fix_req = single_mask & request;
  assign w_fix_gnt = w_fix_req & (~w_fix_req + REQ_ONE);

  assign w_owner_req = |(r_grant & request);
  assign w_xfer      = out_ready & w_owner_req;
  assign w_last      = |(r_grant & request & req_last);
  assign w_cnt_inc   = r_hold_cnt + CNT_ONE;
  assign w_max_hit   = (MAX_HOLD != 0) && w_xfer && (w_cnt_inc == CNT_LIMIT);
  assign w_release   = ~w_owner_req | (w_xfer & w_last) | w_max_hit;

  always_comb begin
    w_next_state   = r_state;
    w_next_grant   = r_grant;
    w_next_base    = r_base_ptr;
    w_next_cnt     = r_hold_cnt;
    w_next_rr_mode = r_rr_mode;
    case (r_state)
      S_IDLE: begin
        if (arb_enable) begin
          if (|request) begin
            w_next_grant   = w_rr_gnt;
            w_next_rr_mode = 1'b1;
            w_next_state   = S_HOLD;
          end
        end else if (|w_fix_req) begin
          w_next_grant   = w_fix_gnt;
          w_next_rr_mode = 1'b0;
          w_next_state   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_release) begin
          w_next_grant = '0;
          w_next_cnt   = '0;
          w_next_state = S_IDLE;
          if (r_rr_mode) begin
            w_next_base = {r_grant[NUM_REQ-2:0], r_grant[NUM_REQ-1]};
          end
        end else if (w_xfer) begin
          w_next_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_grant = '0;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_next_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_next_grant[i]) begin
        w_next_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_base_ptr    <= REQ_ONE;
      r_hold_cnt    <= '0;
      r_rr_mode     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_grant       <= w_next_grant;
      r_grant_valid <= |w_next_grant;
      r_grant_idx   <= w_next_idx;
      r_base_ptr    <= w_next_base;
      r_hold_cnt    <= w_next_cnt;
      r_rr_mode     <= w_next_rr_mode;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign base_ptr    = r_base_ptr;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: directed scenarios plus random traffic,
// expectations from an owner/pointer reference model, checked at negedge.
module tb_rr_hold_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         arb_enable = 1'b1;
  logic [N-1:0] single_mask = 4'b0001;
  logic [N-1:0] request = '0;
  logic [N-1:0] req_last = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [N-1:0] base_ptr;

  rr_hold_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .arb_enable(arb_enable), .single_mask(single_mask),
    .request(request), .req_last(req_last), .out_ready(out_ready),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .base_ptr(base_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         v;
    logic [1:0]   idx;
    logic [N-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: who owns the port, the priority index, beats so far.
  int m_owner = -1;
  int m_base  = 0;
  int m_cnt   = 0;
  bit m_rr    = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e.g   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.v   = (m_owner >= 0);
    e.idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.b   = 4'(1 << m_base);
    return e;
  endfunction

  task automatic model_release();
    if (m_rr) m_base = (m_owner + 1) % N;
    m_owner = -1;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit en, input bit [N-1:0] msk, input bit [N-1:0] req,
                            input bit [N-1:0] lst, input bit rdy);
    if (m_owner < 0) begin
      if (en) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_base + k) % N;
          if (req[i] && m_owner < 0) begin
            m_owner = i;
            m_rr    = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (msk[i] && req[i] && m_owner < 0) begin
            m_owner = i;
            m_rr    = 1'b0;
          end
        end
      end
    end else if (!req[m_owner]) begin
      model_release();
    end else if (rdy) begin
      m_cnt++;
      if (lst[m_owner] || (MH != 0 && m_cnt == MH)) model_release();
    end
  endtask

  task automatic step(input bit en, input bit [N-1:0] msk, input bit [N-1:0] req,
                      input bit [N-1:0] lst, input bit rdy);
    arb_enable  = en;
    single_mask = msk;
    request     = req;
    req_last    = lst;
    out_ready   = rdy;
    model_step(en, msk, req, lst, rdy);
    @(posedge clk);
    exp_q.push_back(model_out());
    #1;
  endtask

  // Called just after a posedge; the expectation already queued for this
  // cycle is replaced, since the async reset overrides it before negedge.
  task automatic do_reset();
    rst_n     = 1'b0;
    request   = '0;
    req_last  = '0;
    out_ready = 1'b0;
    m_owner = -1;
    m_base  = 0;
    m_cnt   = 0;
    m_rr    = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_q.push_back(model_out());
    end
    @(posedge clk);
    exp_q.push_back(model_out());
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 8'(grant), 8'(e.g));
        chk("grant_valid", 8'(grant_valid), 8'(e.v));
        chk("grant_idx", 8'(grant_idx), 8'(e.idx));
        chk("base_ptr", 8'(base_ptr), 8'(e.b));
      end
    end
  end

  initial begin : driver
    bit [N-1:0] rq;
    bit [N-1:0] msk;
    do_reset();

    // Full rotation with single-flit packets.
    repeat (10) step(1'b1, 4'b0001, 4'b1111, 4'b1111, 1'b1);

    // 3-flit packet on req 2 with a two-cycle stall, req 0 waiting.
    do_reset();
    step(1'b1, 4'b0001, 4'b0100, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 4'b0101, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 4'b0101, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0101, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0101, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 4'b0101, 4'b0100, 1'b1);
    step(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0);

    // Burst limit: req 1 streams without last, req 3 waiting.
    do_reset();
    repeat (8) step(1'b1, 4'b0001, 4'b1010, 4'b0000, 1'b1);

    // Abandon before any transfer.
    do_reset();
    step(1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Fixed mode, then a request set that never matches the mask.
    do_reset();
    step(1'b0, 4'b0100, 4'b1111, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 4'b1111, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 4'b1111, 4'b1111, 1'b1);
    repeat (4) step(1'b0, 4'b0100, 4'b1011, 4'b1011, 1'b1);

    // Async reset mid-packet on req 3, then regrant.
    step(1'b1, 4'b0001, 4'b1000, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 4'b1000, 4'b0000, 1'b1);
    do_reset();
    step(1'b1, 4'b0001, 4'b1000, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 4'b1000, 4'b0000, 1'b0);

    // Random traffic with occasional mode switches and resets.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 200 == 0) begin
        do_reset();
      end else begin
        rq  = rq ^ (4'($urandom) & 4'($urandom));
        msk = ($urandom % 10 == 0) ? 4'($urandom) : 4'(1 << ($urandom % N));
        step(($urandom % 6) != 0, msk, rq, 4'($urandom) & 4'($urandom), ($urandom % 4) != 0);
      end
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Registered round-robin arbiter with packet-level grant hold, for NUM_REQ requesters sharing one downstream datapath port. It generalises the combinational fixed/base-priority arbiter in three ways: an internal rotating priority pointer, a grant that stays locked for a multi-flit packet, and a forced-rotation burst limit. The fixed one-hot bypass mode (`arb_enable`=0, `single_mask`) is retained. It sits in front of router output ports and merge points in the datapath.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- MAX_HOLD, 16, max transfers per grant before forced release; 0 = unlimited
- IDX_W, $clog2(NUM_REQ), width of `grant_idx`
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- arb_enable  in  1  1 = round-robin mode; 0 = fixed mode using `single_mask`
- single_mask  in  NUM_REQ  one-hot select for fixed mode
- request  in  NUM_REQ  per-requester request/valid
- req_last  in  NUM_REQ  per-requester last-flit flag, qualified by its `request`
- out_ready  in  1  downstream accepts the current flit
- grant  out  NUM_REQ  registered one-hot grant
- grant_valid  out  1  `|grant`, registered
- grant_idx  out  IDX_W  binary index of `grant`; 0 when no grant
- base_ptr  out  NUM_REQ  one-hot round-robin priority base

## Operation
- States: IDLE (no grant) and HOLD (grant locked).
- IDLE, `arb_enable`=1: the winner is the first set bit of `request` scanning upward from `base_ptr` with wrap (bit NUM_REQ-1 → bit 0). Winner is registered into `grant`. Go to HOLD. No request: stay in IDLE.
- IDLE, `arb_enable`=0: if `single_mask & request` ≠ 0, grant = `single_mask`, go to HOLD. Multi-hot `single_mask` is illegal. In that case the lowest set bit of `single_mask & request` is granted.
- Mode and `single_mask` are sampled only in IDLE. Changes during HOLD take effect after release.
- HOLD transfer: `grant_valid & out_ready & |(grant & request)`. Each transfer increments `hold_cnt` (width $clog2(MAX_HOLD+1)).
- Release conditions (any one):
  - a transfer with `req_last` of the granted requester set;
  - a transfer that makes `hold_cnt` equal MAX_HOLD (when MAX_HOLD ≠ 0);
  - the granted requester deasserts `request` (abandon; no transfer counted).
- On release:
  - `grant` ← 0, `hold_cnt` ← 0, state ← IDLE;
  - in round-robin mode only, `base_ptr` ← grant rotated left by 1 (so the winner gets lowest priority next);
  - fixed mode never changes `base_ptr`.
- `out_ready` low in HOLD: the grant is held indefinitely and the counter is frozen.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `grant_idx`=0, `base_ptr`=1 (bit 0), state IDLE, `hold_cnt`=0.
- Request-to-grant latency: `request` sampled at edge t gives `grant` valid after edge t, usable in cycle t+1.
- Release sampled at edge t gives `grant`=0 in cycle t+1. The next grant appears at the earliest in cycle t+2, a mandatory one-cycle bubble between grants.
- A single-flit packet (`req_last`=1 with `out_ready`=1 in the first granted cycle) occupies exactly one grant cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `rst_n` asserted mid-HOLD clears all state immediately (asynchronous). After deassertion, arbitration restarts from `base_ptr`=1.
- Simultaneous release and new requests: the new winner is computed in the IDLE cycle using the already-rotated `base_ptr`.

## Test plan
- Reset, then `request`=4'b1111 with `req_last`=4'b1111 and `out_ready`=1 held → grants 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; `base_ptr` updates as 0010, 0100, 1000, 0001.
- 3-flit packet on req 2 (`req_last` on the 3rd transfer) with `out_ready` low for 2 cycles mid-packet, req 0 also requesting → `grant`=0100 for 5 cycles, then 0000, then 0001.
- MAX_HOLD=4, req 1 streams with `req_last`=0 and req 3 requesting → release after 4 transfers, `base_ptr`=0100, next grant 1000.
- Abandon: req 0 granted, drops `request` with no transfer → `grant`=0 next cycle, `base_ptr`=0010, `hold_cnt` stays 0.
- Fixed mode: `arb_enable`=0, `single_mask`=0100, `request`=1111 → `grant`=0100 and `base_ptr` unchanged after release. With `request`=1011 → no grant ever.
- Async reset pulse while `grant`=1000 mid-packet → all outputs at reset values in the same cycle. After reset, `request`=1000 → `grant`=1000 one cycle later.
